// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg -- shared definitions for the PC generator.
//   PC_W_DEF       : default program-counter width in bits
//   RESET_VEC_DEF  : default PC value loaded on reset
//   redir_src_e    : which source supplies the next PC
//                    (SEQ, BR, RET, EXC, PEND)
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int          PC_W_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        RET,
        EXC,
        PEND
    } redir_src_e;

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras -- circular return-address stack.
// Ports:
//   clk, rst   : clock, synchronous active-low reset (clears pointer/count)
//   push       : write push_data on top of the stack
//   push_data  : return address to push
//   pop        : discard the top entry (ignored when empty)
//   top        : current top-of-stack value (valid when !empty)
//   empty/full : occupancy flags
// A push to a full stack overwrites the oldest entry. The count saturates at
// DEPTH, so the stack keeps the DEPTH most recent return addresses.
// ---------------------------------------------------------------------------
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_reg;      // next free slot
    logic [PTR_W:0]   count_reg;
    logic [PTR_W-1:0] top_idx;

    // Pointer wraps naturally because DEPTH is a power of two; the slot the
    // pointer lands on when full is exactly the oldest entry.
    assign top_idx = ptr_reg - 1'b1;
    assign top     = mem[top_idx];
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + 1'b1;
            if (!full) begin
                count_reg <= count_reg + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_reg   <= ptr_reg - 1'b1;
            count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset; entries are only ever read below the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator with redirect holding and an
// optional return-address stack (enabled by defining PC_GEN_RAS_EN).
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-low reset
//   en         : advance enable (0 = stall)
//   exc_valid, exc_vec  : exception redirect (highest priority)
//   br_valid, br_target : branch/jump redirect
//   call       : current br redirect is a call (pushes pc+INC)
//   ret        : current instruction is a return (pops the RAS)
//   pc         : current fetch PC
//   pend       : a redirect captured during a stall is waiting
//   ras_uflow  : one-cycle pulse after a pop from an empty stack
// Next-PC priority when en=1: exc > pending > br > RAS top (ret) > pc+INC.
// ---------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_vec,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic            pend,
    output logic            ras_uflow
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pend_tgt_reg;
    logic            pend_reg;
    logic            pend_exc_reg;   // pending target came from an exception
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ret_req;
    redir_src_e      src;

    // Wraps modulo 2^PC_W by construction.
    assign pc_seq = pc_reg + PC_W'(INC);

    always_comb begin
        src = SEQ;
        if (exc_valid) begin
            src = EXC;
        end else if (pend_reg) begin
            src = PEND;
        end else if (br_valid) begin
            src = BR;
        end else if (ret_req) begin
            src = RET;
        end
    end

    always_comb begin
        pc_next = pc_seq;
        case (src)
            EXC:     pc_next = exc_vec;
            PEND:    pc_next = pend_tgt_reg;
            BR:      pc_next = br_target;
            RET:     pc_next = ras_empty ? pc_seq : ras_top;
            default: pc_next = pc_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_VEC;
            pend_reg     <= 1'b0;
            pend_exc_reg <= 1'b0;
            pend_tgt_reg <= '0;
        end else if (en) begin
            // The pending slot is consumed on the first enabled edge even
            // when an exception overrides it.
            pc_reg       <= pc_next;
            pend_reg     <= 1'b0;
            pend_exc_reg <= 1'b0;
        end else if (exc_valid) begin
            pend_reg     <= 1'b1;
            pend_exc_reg <= 1'b1;
            pend_tgt_reg <= exc_vec;
        end else if (br_valid && !(pend_reg && pend_exc_reg)) begin
            pend_reg     <= 1'b1;
            pend_exc_reg <= 1'b0;
            pend_tgt_reg <= br_target;
        end
    end

    assign pc   = pc_reg;
    assign pend = pend_reg;

`ifdef PC_GEN_RAS_EN
    logic pend_call_reg;   // pending br was a call; push when it is applied
    logic uflow_reg;
    logic ras_push;
    logic ras_pop;
    logic ras_full_unused;

    assign ret_req  = ret;
    assign ras_push = rst && en && ((src == PEND && pend_call_reg) || (src == BR && call));
    assign ras_pop  = rst && en && (src == RET);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_call_reg <= 1'b0;
            uflow_reg     <= 1'b0;
        end else begin
            uflow_reg <= ras_pop && ras_empty;
            if (!en) begin
                if (exc_valid) begin
                    pend_call_reg <= 1'b0;
                end else if (br_valid && !(pend_reg && pend_exc_reg)) begin
                    pend_call_reg <= call;
                end
            end
        end
    end

    assign ras_uflow = uflow_reg;
`else
    logic [31:0] ras_unused;

    assign ret_req    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_unused = {30'd0, call, ret} ^ 32'(RAS_DEPTH);
    assign ras_uflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// A queue-based reference model tracks pc, the pending redirect and the
// return-address stack; every cycle the DUT outputs are compared #1 after
// the rising edge. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_vec = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic        pend;
    logic        ras_uflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    bit          m_pend = 1'b0;
    bit          m_pexc = 1'b0;
    bit          m_pcall = 1'b0;
    logic [31:0] m_ptgt = '0;
    bit          m_uflow = 1'b0;
    logic [31:0] ras_q[$];

    pc_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .exc_valid (exc_valid),
        .exc_vec   (exc_vec),
        .br_valid  (br_valid),
        .br_target (br_target),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .pend      (pend),
        .ras_uflow (ras_uflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void ras_push(logic [31:0] v);
        if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
        ras_q.push_back(v);
    endfunction

    // One rising edge of the reference behaviour, using the sampled inputs.
    function automatic void model_step();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (!rst) begin
            m_pc = 32'h0; m_pend = 0; m_pexc = 0; m_pcall = 0; m_uflow = 0;
            ras_q.delete();
        end else begin
            m_uflow = 0;
            if (en) begin
                if (exc_valid) begin
                    m_pc = exc_vec;
                end else if (m_pend) begin
                    if (RAS_ON && m_pcall) ras_push(seq);
                    m_pc = m_ptgt;
                end else if (br_valid) begin
                    if (RAS_ON && call) ras_push(seq);
                    m_pc = br_target;
                end else if (RAS_ON && ret) begin
                    if (ras_q.size() == 0) begin
                        m_pc = seq;
                        m_uflow = 1;
                    end else begin
                        m_pc = ras_q.pop_back();
                    end
                end else begin
                    m_pc = seq;
                end
                m_pend = 0;
                m_pexc = 0;
            end else if (exc_valid) begin
                m_pend = 1; m_pexc = 1; m_pcall = 0; m_ptgt = exc_vec;
            end else if (br_valid && !(m_pend && m_pexc)) begin
                m_pend = 1; m_pexc = 0; m_pcall = call; m_ptgt = br_target;
            end
        end
    endfunction

    task automatic cyc(input bit r, input bit e, input bit xv, input logic [31:0] xvec,
                       input bit bv, input logic [31:0] bt, input bit c, input bit rt);
        rst = r; en = e; exc_valid = xv; exc_vec = xvec;
        br_valid = bv; br_target = bt; call = c; ret = rt;
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("pend", {31'd0, pend}, {31'd0, m_pend});
        chk("ras_uflow", {31'd0, ras_uflow}, {31'd0, m_uflow});
        $display("t=%0t rst=%0b en=%0b exc=%0b br=%0b call=%0b ret=%0b -> pc=%h pend=%0b uflow=%0b",
                 $time, r, e, xv, bv, c, rt, pc, pend, ras_uflow);
    endtask

    initial begin
        // Reset, including a pending redirect discarded by reset
        cyc(0, 1, 0, 0, 1, 32'h40, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        cyc(1, 0, 0, 0, 1, 32'h77, 0, 0);
        chk("stall_pend", {31'd0, pend}, 32'd1);
        cyc(0, 1, 0, 0, 1, 32'h40, 0, 0);
        chk("rst_clr_pc", pc, 32'h0);
        chk("rst_clr_pend", {31'd0, pend}, 32'd0);

        // Sequential increments
        cyc(1, 1, 0, 0, 0, 0, 0, 0); chk("seq1", pc, 32'h4);
        cyc(1, 1, 0, 0, 0, 0, 0, 0); chk("seq2", pc, 32'h8);
        cyc(1, 1, 0, 0, 0, 0, 0, 0); chk("seq3", pc, 32'hC);

        // Wrap-around
        cyc(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0); chk("br_top", pc, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);             chk("wrap", pc, 32'h0);

        // Stalled br then exc: exc wins when released
        cyc(1, 0, 0, 0, 1, 32'h100, 0, 0); chk("pend_br", {31'd0, pend}, 32'd1);
        chk("stall_hold", pc, 32'h0);
        cyc(1, 0, 1, 32'h80, 0, 0, 0, 0);  chk("pend_exc", {31'd0, pend}, 32'd1);
        cyc(1, 0, 0, 0, 1, 32'h300, 0, 0); // ignored behind the exc
        cyc(1, 1, 0, 0, 0, 0, 0, 0);       chk("pend_apply", pc, 32'h80);
        chk("pend_clr", {31'd0, pend}, 32'd0);

        // exc and br together: exc wins, no push even with call
        cyc(1, 1, 1, 32'h80, 1, 32'h200, 1, 0); chk("exc_win", pc, 32'h80);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);            chk("no_push_ret", pc, 32'h84);

`ifdef PC_GEN_RAS_EN
        chk("no_push_uflow", {31'd0, ras_uflow}, 32'd1);
        // Call/return pair then underflow
        cyc(1, 1, 0, 0, 1, 32'h10, 0, 0);  chk("to_10", pc, 32'h10);
        cyc(1, 1, 0, 0, 1, 32'h400, 1, 0); chk("call", pc, 32'h400);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);       chk("ret1", pc, 32'h14);
        chk("ret1_uflow", {31'd0, ras_uflow}, 32'd0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);       chk("ret2", pc, 32'h18);
        chk("ret2_uflow", {31'd0, ras_uflow}, 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);       chk("uflow_pulse", {31'd0, ras_uflow}, 32'd0);

        // Five calls overflow a 4-deep stack
        for (int i = 1; i <= 5; i++) cyc(1, 1, 0, 0, 1, 32'(i) << 12, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("lifo1", pc, 32'h4004);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("lifo2", pc, 32'h3004);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("lifo3", pc, 32'h2004);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("lifo4", pc, 32'h1004);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("lifo5", pc, 32'h1008);
        chk("lifo5_uflow", {31'd0, ras_uflow}, 32'd1);
`else
        chk("no_ras_uflow", {31'd0, ras_uflow}, 32'd0);
        cyc(1, 1, 0, 0, 0, 0, 0, 1); chk("ret_ignored", pc, 32'h88);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(63) != 0),
                ($urandom_range(3) != 0),
                ($urandom_range(15) == 0), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(3) == 0), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(1) == 0),
                ($urandom_range(3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
